// File: rtl/ex_alu_md.sv
// Execute-stage ALU: RV32I ops from raw decode fields, iterative RV32M mul/div.
// Latency: 1 cycle for base ops and divide special cases, XLEN cycles for mul/div.
// Backpressure: in_ready_o low while iterating; no output backpressure.
module ex_alu_md #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [6:0]      opcode_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            out_valid_o,
    output logic            busy_o
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO, SEL_REM} sel_t;

    state_t state, state_next;
    sel_t   md_sel, sel_q;

    logic [SHW-1:0]    cnt;
    logic [2*XLEN-1:0] acc, mul_next, div_next, prod;
    logic [XLEN-1:0]   b_reg, a_mag, b_mag, base_res, single_res, md_res;
    logic [XLEN:0]     mul_sum, div_r, div_d;
    logic              neg_q, neg_r, a_sgn, b_sgn, a_neg, b_neg;
    logic              start_mul, start_div, accept;
    logic [SHW-1:0]    shamt;

    assign shamt      = src2_i[SHW-1:0];
    assign in_ready_o = (state == S_IDLE) & rst_i;
    assign busy_o     = (state != S_IDLE);
    assign accept     = in_valid_i & in_ready_o & ~flush_i;

    // funct7[5] selects sub only for R-type; on OP-IMM it is an immediate bit.
    always_comb begin
        base_res = '0;
        case (funct3_i)
            3'd0: base_res = (alu_op_i[1] & funct7_i[5]) ? src1_i - src2_i : src1_i + src2_i;
            3'd1: base_res = src1_i << shamt;
            3'd2: base_res = {{(XLEN-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            3'd3: base_res = {{(XLEN-1){1'b0}}, src1_i < src2_i};
            3'd4: base_res = src1_i ^ src2_i;
            3'd5: base_res = funct7_i[5] ? XLEN'($signed(src1_i) >>> shamt) : src1_i >> shamt;
            3'd6: base_res = src1_i | src2_i;
            default: base_res = src1_i & src2_i;
        endcase
    end

    always_comb begin
        single_res = '0;
        start_mul  = 1'b0;
        start_div  = 1'b0;
        md_sel     = SEL_LO;
        a_sgn      = 1'b0;
        b_sgn      = 1'b0;
        case (alu_op_i)
            2'b00: begin
                if (opcode_i == OPC_OPIMM)
                    single_res = base_res;
                else if (opcode_i == OPC_LOAD || opcode_i == OPC_STORE || opcode_i == OPC_JALR)
                    single_res = src1_i + src2_i;
            end
            2'b01: single_res = src1_i - src2_i;
            2'b10: begin
                if (funct7_i == 7'h00 || funct7_i == 7'h20) begin
                    single_res = base_res;
                end else if (M_EXT && funct7_i == 7'h01) begin
                    if (!funct3_i[2]) begin
                        start_mul = 1'b1;
                        md_sel    = (funct3_i == 3'd0) ? SEL_LO : SEL_HI;
                        a_sgn     = (funct3_i != 3'd3);
                        b_sgn     = !funct3_i[1];
                    end else begin
                        md_sel = funct3_i[1] ? SEL_REM : SEL_QUO;
                        a_sgn  = !funct3_i[0];
                        b_sgn  = !funct3_i[0];
                        if (src2_i == '0)
                            single_res = funct3_i[1] ? src1_i : '1;
                        else if (!funct3_i[0] && src1_i == INT_MIN && src2_i == '1)
                            single_res = funct3_i[1] ? '0 : src1_i;
                        else
                            start_div = 1'b1;
                    end
                end
            end
            default: single_res = src1_i + src2_i;
        endcase
    end

    assign a_neg = a_sgn & src1_i[XLEN-1];
    assign b_neg = b_sgn & src2_i[XLEN-1];
    assign a_mag = a_neg ? -src1_i : src1_i;
    assign b_mag = b_neg ? -src2_i : src2_i;

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right per step.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}.
    assign div_r    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_d    = div_r - {1'b0, b_reg};
    assign div_next = div_d[XLEN] ? {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {div_d[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod = neg_q ? -mul_next : mul_next;

    always_comb begin
        case (sel_q)
            SEL_LO:  md_res = prod[XLEN-1:0];
            SEL_HI:  md_res = prod[2*XLEN-1:XLEN];
            SEL_QUO: md_res = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
            default: md_res = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && start_mul)      state_next = S_MUL;
                else if (accept && start_div) state_next = S_DIV;
            end
            default: begin
                if (flush_i || cnt == CNT_LAST) state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt         <= '0;
            acc         <= '0;
            b_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            sel_q       <= SEL_LO;
            result_o    <= '0;
            zero_o      <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            if (state == S_IDLE) begin
                if (accept && (start_mul || start_div)) begin
                    cnt   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    sel_q <= md_sel;
                    acc   <= {{XLEN{1'b0}}, start_mul ? b_mag : a_mag};
                    b_reg <= start_mul ? a_mag : b_mag;
                end else if (accept) begin
                    result_o    <= single_res;
                    zero_o      <= (single_res == '0);
                    out_valid_o <= 1'b1;
                end
            end else if (!flush_i) begin
                acc <= (state == S_MUL) ? mul_next : div_next;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    result_o    <= md_res;
                    zero_o      <= (md_res == '0);
                    out_valid_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_alu_md.sv
// Directed bench for ex_alu_md: base ops, mul/div timing, special divides, flush, reset, M_EXT=0.
module tb_ex_alu_md;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_valid1, flush;
    logic [1:0]  alu_op;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    logic [31:0] a, b;
    logic [31:0] result, result1;
    logic        zero, zero1, out_valid, out_valid1, busy, busy1, in_ready, in_ready1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ex_alu_md #(.XLEN(32), .M_EXT(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_op_i(alu_op), .funct3_i(f3), .funct7_i(f7), .opcode_i(opc),
        .src1_i(a), .src2_i(b), .flush_i(flush),
        .result_o(result), .zero_o(zero), .out_valid_o(out_valid), .busy_o(busy)
    );

    ex_alu_md #(.XLEN(32), .M_EXT(1'b0)) dut_nom (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .alu_op_i(alu_op), .funct3_i(f3), .funct7_i(f7), .opcode_i(opc),
        .src1_i(a), .src2_i(b), .flush_i(flush),
        .result_o(result1), .zero_o(zero1), .out_valid_o(out_valid1), .busy_o(busy1)
    );

    task automatic set_op(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                          input logic [6:0] oc, input logic [31:0] x, input logic [31:0] y);
        alu_op = op; f3 = fn3; f7 = fn7; opc = oc; a = x; b = y;
    endtask

    task automatic issue();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; reports edges waited and whether in_ready rose meanwhile.
    task automatic wait_done(output int cyc, output bit rdy_seen);
        cyc = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL rst_result: got %h want 0", result); else passed++;
        checks++; if ({zero, out_valid, busy} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {zero, out_valid, busy}); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_single();
        set_op(2'b10, 3'd0, 7'h00, OP_R, 32'd5, 32'd7); issue();
        checks++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else passed++;
        checks++; if (result !== 32'd12) $display("FAIL add_result: got %h want %h", result, 32'd12); else passed++;
        checks++; if (zero !== 1'b0) $display("FAIL add_zero: got %b want 0", zero); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL add_pulse: got %b want 0", out_valid); else passed++;

        set_op(2'b01, 3'd0, 7'h00, OP_B, 32'h1234, 32'h1234); issue();
        checks++; if ({result, zero} !== {32'h0, 1'b1})
            $display("FAIL beq: got %h/%b want 0/1", result, zero); else passed++;

        set_op(2'b10, 3'd5, 7'h20, OP_R, 32'h80000000, 32'd4); issue();
        checks++; if (result !== 32'hF8000000) $display("FAIL sra: got %h want F8000000", result); else passed++;

        // srai with the funct7 bit present in the immediate: only shamt bits count
        set_op(2'b00, 3'd5, 7'h20, OP_I, 32'h80000000, 32'h404); issue();
        checks++; if (result !== 32'hF8000000) $display("FAIL srai: got %h want F8000000", result); else passed++;

        set_op(2'b10, 3'd3, 7'h00, OP_R, 32'd1, 32'hFFFFFFFF); issue();
        checks++; if (result !== 32'd1) $display("FAIL sltu: got %h want 1", result); else passed++;

        set_op(2'b10, 3'd2, 7'h00, OP_R, 32'd1, 32'hFFFFFFFF); issue();
        checks++; if (result !== 32'd0) $display("FAIL slt: got %h want 0", result); else passed++;

        // addi with funct7[5]=1 in the immediate must still add
        set_op(2'b00, 3'd0, 7'h20, OP_I, 32'd10, 32'h400); issue();
        checks++; if (result !== 32'h40A) $display("FAIL addi: got %h want 40A", result); else passed++;

        set_op(2'b00, 3'd0, 7'h00, OP_LU, 32'd9, 32'd9); issue();
        checks++; if ({out_valid, result, zero} !== {1'b1, 32'h0, 1'b1})
            $display("FAIL unsupported: got %b/%h/%b want 1/0/1", out_valid, result, zero); else passed++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        set_op(2'b11, 3'd0, 7'h00, 7'b1101111, 32'h1000, 32'h8);
        @(posedge clk); #1;
        checks++; if ({out_valid, result} !== {1'b1, 32'h1008})
            $display("FAIL b2b_jal: got %b/%h want 1/1008", out_valid, result); else passed++;
        set_op(2'b10, 3'd4, 7'h00, OP_R, 32'hF0, 32'hFF);
        @(posedge clk); #1;
        checks++; if ({out_valid, result} !== {1'b1, 32'h0F})
            $display("FAIL b2b_xor: got %b/%h want 1/0F", out_valid, result); else passed++;
        set_op(2'b10, 3'd1, 7'h00, OP_R, 32'h1, 32'h3F);
        @(posedge clk); #1;
        checks++; if ({out_valid, result} !== {1'b1, 32'h80000000})
            $display("FAIL b2b_sll: got %b/%h want 1/80000000", out_valid, result); else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        int cyc;
        bit rdy;
        set_op(2'b10, 3'd1, 7'h01, OP_R, 32'hFFFFFFFF, 32'hFFFFFFFF); issue();
        checks++; if (busy !== 1'b1) $display("FAIL mulh_busy: got %b want 1", busy); else passed++;
        wait_done(cyc, rdy);
        // accepted at edge N, result in cycle N+33: 32 further edges
        checks++; if (cyc !== 32) $display("FAIL mulh_latency: got %0d edges want 32", cyc); else passed++;
        checks++; if (rdy !== 1'b0) $display("FAIL mulh_ready_low: in_ready seen %b want 0", rdy); else passed++;
        checks++; if ({result, zero, busy, in_ready} !== {32'h0, 1'b1, 1'b0, 1'b1})
            $display("FAIL mulh_result: got %h/%b/%b/%b want 0/1/0/1", result, zero, busy, in_ready); else passed++;

        set_op(2'b10, 3'd0, 7'h01, OP_R, 32'd7, 32'hFFFFFFFD); issue();
        wait_done(cyc, rdy);
        checks++; if (result !== 32'hFFFFFFEB) $display("FAIL mul_neg: got %h want FFFFFFEB", result); else passed++;

        set_op(2'b10, 3'd3, 7'h01, OP_R, 32'hFFFFFFFF, 32'hFFFFFFFF); issue();
        wait_done(cyc, rdy);
        checks++; if (result !== 32'hFFFFFFFE) $display("FAIL mulhu: got %h want FFFFFFFE", result); else passed++;

        set_op(2'b10, 3'd2, 7'h01, OP_R, 32'hFFFFFFFF, 32'h2); issue();
        wait_done(cyc, rdy);
        checks++; if (result !== 32'hFFFFFFFF) $display("FAIL mulhsu: got %h want FFFFFFFF", result); else passed++;
    endtask

    task automatic test_div();
        int cyc;
        bit rdy;
        set_op(2'b10, 3'd4, 7'h01, OP_R, 32'hFFFFFFF9, 32'd2); issue();
        wait_done(cyc, rdy);
        checks++; if (cyc !== 32) $display("FAIL div_latency: got %0d edges want 32", cyc); else passed++;
        checks++; if (result !== 32'hFFFFFFFD) $display("FAIL div_neg: got %h want FFFFFFFD", result); else passed++;
        // new op accepted in the completion cycle
        set_op(2'b10, 3'd6, 7'h01, OP_R, 32'hFFFFFFF9, 32'd2); issue();
        checks++; if (busy !== 1'b1) $display("FAIL rem_accept_on_done: busy %b want 1", busy); else passed++;
        wait_done(cyc, rdy);
        checks++; if (result !== 32'hFFFFFFFF) $display("FAIL rem_neg: got %h want FFFFFFFF", result); else passed++;

        set_op(2'b10, 3'd5, 7'h01, OP_R, 32'd100, 32'd0); issue();
        checks++; if ({out_valid, busy, result} !== {1'b1, 1'b0, 32'hFFFFFFFF})
            $display("FAIL divu_by0: got %b/%b/%h want 1/0/FFFFFFFF", out_valid, busy, result); else passed++;

        set_op(2'b10, 3'd7, 7'h01, OP_R, 32'd100, 32'd0); issue();
        checks++; if ({out_valid, result} !== {1'b1, 32'd100})
            $display("FAIL remu_by0: got %b/%h want 1/64", out_valid, result); else passed++;

        set_op(2'b10, 3'd4, 7'h01, OP_R, 32'h80000000, 32'hFFFFFFFF); issue();
        checks++; if ({out_valid, busy, result} !== {1'b1, 1'b0, 32'h80000000})
            $display("FAIL div_ovf: got %b/%b/%h want 1/0/80000000", out_valid, busy, result); else passed++;

        set_op(2'b10, 3'd6, 7'h01, OP_R, 32'h80000000, 32'hFFFFFFFF); issue();
        checks++; if ({out_valid, result, zero} !== {1'b1, 32'h0, 1'b1})
            $display("FAIL rem_ovf: got %b/%h/%b want 1/0/1", out_valid, result, zero); else passed++;

        set_op(2'b10, 3'd5, 7'h01, OP_R, 32'd1000, 32'd7); issue();
        wait_done(cyc, rdy);
        checks++; if (result !== 32'd142) $display("FAIL divu: got %h want 8E", result); else passed++;
    endtask

    task automatic test_flush();
        bit seen;
        set_op(2'b10, 3'd0, 7'h00, OP_R, 32'h50, 32'h5); issue();
        set_op(2'b10, 3'd5, 7'h01, OP_R, 32'd1000, 32'd3); issue();
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if ({busy, out_valid, in_ready} !== 3'b001)
            $display("FAIL flush_idle: busy/valid/ready %b want 001", {busy, out_valid, in_ready}); else passed++;
        checks++; if (result !== 32'h55) $display("FAIL flush_result_kept: got %h want 55", result); else passed++;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL flush_no_valid: late out_valid %b want 0", seen); else passed++;

        set_op(2'b10, 3'd0, 7'h00, OP_R, 32'd1, 32'd1);
        flush = 1'b1;
        issue();
        flush = 1'b0;
        checks++; if ({out_valid, busy, result} !== {1'b0, 1'b0, 32'h55})
            $display("FAIL flush_blocks_accept: got %b/%b/%h want 0/0/55", out_valid, busy, result); else passed++;
    endtask

    task automatic test_reset_mid();
        set_op(2'b10, 3'd0, 7'h00, OP_R, 32'h10, 32'h20); issue();
        set_op(2'b10, 3'd0, 7'h01, OP_R, 32'd3, 32'd5); issue();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, out_valid, zero, result} !== {3'b000, 32'h0})
            $display("FAIL reset_mid: busy/valid/zero %b result %h want 000/0", {busy, out_valid, zero}, result);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_mid_after: ready/valid %b want 10", {in_ready, out_valid}); else passed++;
    endtask

    task automatic test_no_mext();
        set_op(2'b10, 3'd0, 7'h01, OP_R, 32'd3, 32'd4);
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++; if ({out_valid1, busy1, result1, zero1} !== {2'b10, 32'h0, 1'b1})
            $display("FAIL nomext_mul: got %b/%b/%h/%b want 1/0/0/1", out_valid1, busy1, result1, zero1);
        else passed++;
        set_op(2'b10, 3'd0, 7'h00, OP_R, 32'd3, 32'd4);
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++; if ({out_valid1, result1} !== {1'b1, 32'd7})
            $display("FAIL nomext_add: got %b/%h want 1/7", out_valid1, result1); else passed++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; flush = 1'b0;
        set_op(2'b00, 3'd0, 7'h00, 7'h00, 32'h0, 32'h0);
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_no_mext();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ex_alu_md.md
# ex_alu_md

Parametrised execute-stage ALU for the pipelined RISC-V CPU. It takes the raw decode fields (ALUop, funct3, funct7, opcode) and operands, and produces the result and zero flag. It replaces the separate combinational ALU-control/ALU pair. Base RV32I ALU operations complete in one cycle. RV32M multiply/divide runs iteratively over XLEN cycles under a valid/ready handshake that the hazard unit uses to stall ID/EX.

## Interface
- XLEN, 32, operand/result width; power of two, minimum 8
- M_EXT, 1, 1 enables MUL/DIV/REM decoding; 0 decodes funct7=0x01 R-type as unsupported
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-low reset
- in_valid_i  in  1  operation presented this cycle
- in_ready_o  out  1  unit can accept; 1 only in IDLE with rst_i high
- alu_op_i  in  2  00 I/S/load/jalr, 01 branch, 10 R-type, 11 jal
- funct3_i  in  3  instruction funct3
- funct7_i  in  7  instruction funct7
- opcode_i  in  7  instruction opcode
- src1_i  in  XLEN  operand A (rs1 or PC)
- src2_i  in  XLEN  operand B (rs2 or immediate)
- flush_i  in  1  kill in-flight operation (branch mispredict)
- result_o  out  XLEN  registered result, held until next completion
- zero_o  out  1  registered, result_o == 0
- out_valid_o  out  1  one-cycle pulse, result_o/zero_o new this cycle
- busy_o  out  1  iterative operation in progress; stall request

## Operation
- Decode on acceptance (in_valid_i & in_ready_o):
  - ALUop 00:
    - opcode 0010011: funct3 0 addi, 1 slli, 2 slti, 3 sltiu, 4 xori, 5 srli/srai (funct7[5]), 6 ori, 7 andi.
    - opcodes 0000011, 0100011, 1100111: add.
    - Any other opcode: unsupported.
  - ALUop 01: sub (zero_o drives beq/bne).
  - ALUop 10:
    - funct7 0x00/0x20: add/sub, sll, slt, sltu, xor, srl/sra, or, and by funct3.
    - funct7 0x01 with M_EXT=1: funct3 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
    - Anything else: unsupported.
  - ALUop 11: add.
- Unsupported operations complete in one cycle with result 0.
- Shifts use src2_i[log2(XLEN)-1:0] only; sra is arithmetic.
- slt/sltu results are zero-extended 0/1.
- States: IDLE, MUL, DIV.
  - IDLE accept single-cycle op: register result, stay IDLE.
  - IDLE accept mul-class op: latch operand magnitudes and result-sign flags, counter=0, go MUL.
  - IDLE accept div-class op: same latching, go DIV.
  - MUL: shift-add one multiplier bit per cycle into a 2·XLEN accumulator.
  - DIV: restoring division, one quotient bit per cycle.
  - MUL/DIV → IDLE when counter reaches XLEN-1. Sign-correct via two's complement, select low half, high half, quotient or remainder, pulse out_valid_o.
- Division special cases take the single-cycle path (no DIV state):
  - Divide by zero: quotient all-ones, remainder = src1_i.
  - Signed overflow (src1_i = −2^(XLEN−1), src2_i = −1): quotient = src1_i, remainder 0.
- Signed remainder takes the sign of the dividend.
- busy_o = state != IDLE; in_ready_o = state == IDLE & rst_i.
- flush_i:
  - In MUL/DIV: return to IDLE next edge with no out_valid_o; result_o keeps its old value.
  - In IDLE: blocks acceptance that cycle.
  - Asserted together with in_valid_i: flush wins.
- Reset (rst_i low at an edge): state IDLE, counter 0, result_o 0, zero_o 0, out_valid_o 0, busy_o 0. Reset aborts any operation mid-iteration.

## Timing
- Single-cycle op accepted at edge N: out_valid_o high in cycle N+1, with result_o valid. Back-to-back acceptance every cycle is allowed.
- Iterative op accepted at edge N:
  - busy_o high cycles N+1 … N+XLEN.
  - out_valid_o high in cycle N+XLEN+1, coincident with busy_o low and in_ready_o high.
  - A new op can be accepted in that same cycle.
- Special-case divides: latency 1, identical to single-cycle ops.
- There is no output backpressure; the consumer must take the result in the out_valid_o cycle.

## Test plan
- Reset, then add 5+7 (ALUop 10, f3 0, f7 0x00) → out_valid_o next cycle, result_o 12, zero_o 0.
- beq src1=src2=0x1234 (ALUop 01) → result 0, zero_o 1; sra 0x80000000>>4 → 0xF8000000; sltu 1,0xFFFFFFFF → 1.
- mulh 0xFFFFFFFF × 0xFFFFFFFF → out_valid exactly 33 cycles after accept with 0x00000000; mul 7×−3 → 0xFFFFFFEB; in_ready_o 0 throughout.
- div −7/2 → −3 (0xFFFFFFFD), rem → −1; divu 100/0 → 0xFFFFFFFF in 1 cycle; div 0x80000000/−1 → 0x80000000, rem 0.
- Start divu, assert flush_i at iteration 10 → no out_valid_o, IDLE next cycle, result_o unchanged; in_valid_i with flush_i same cycle → not accepted.
- rst_i low mid-mul at iteration 5 → next cycle busy_o 0, result_o 0; M_EXT=0 instance, mul 3×4 → result 0 in 1 cycle.
